// File: rtl/cv32e41p_sequencer_pkg.sv
// Shared types and instruction encoders for the Zcmp push/pop micro-op sequencer.
// Encoders select word or doubleword memory ops from the xlen argument.
package cv32e41p_sequencer_pkg;

  typedef enum logic [2:0] {
    PUSH,
    POP,
    POPRET,
    POPRETZ,
    MVSA01,
    MVA01S
  } zcmp_op_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd1;
  localparam logic [4:0]  REG_SP   = 5'd2;
  localparam logic [4:0]  REG_A0   = 5'd10;
  localparam logic [4:0]  REG_A1   = 5'd11;
  localparam logic [31:0] UOP_RET  = 32'h0000_8067;  // jalr x0, 0(ra)

  // rlist 4..14 saves ra plus rlist-4 s-regs; 15 saves ra and all twelve s-regs
  function automatic logic [3:0] rlist_count(input logic [3:0] rlist);
    return (rlist == 4'd15) ? 4'd13 : rlist - 4'd3;
  endfunction

  // s0/s1 live at x8/x9, s2 onwards continue at x18
  function automatic logic [4:0] sreg_regnum(input logic [3:0] idx);
    return (idx < 4'd2) ? {1'b0, idx} + 5'd8 : {1'b0, idx} + 5'd16;
  endfunction

  function automatic int align_up(input int value, input int align);
    return (value + align - 1) & ~(align - 1);
  endfunction

  function automatic logic [31:0] enc_store(input int xlen, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [11:0] imm);
    logic [2:0] funct3;
    funct3 = (xlen == 64) ? 3'b011 : 3'b010;
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_load(input int xlen, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm);
    logic [2:0] funct3;
    funct3 = (xlen == 64) ? 3'b011 : 3'b010;
    return {imm, rs1, funct3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

endpackage

// File: rtl/cv32e41p_zcmp_sequencer_if.sv
// Instruction-in / micro-op-out handshake bundle of the Zcmp sequencer.
interface cv32e41p_zcmp_sequencer_if;
  logic [15:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] uop_o;
  logic        uop_valid_o;
  logic        uop_ready_i;
  logic        uop_last_o;
  logic        kill_i;
  logic        illegal_o;
  logic        busy_o;

  modport master (
    output instr_i, instr_valid_i, uop_ready_i, kill_i,
    input  instr_ready_o, uop_o, uop_valid_o, uop_last_o, illegal_o, busy_o
  );

  modport slave (
    input  instr_i, instr_valid_i, uop_ready_i, kill_i,
    output instr_ready_o, uop_o, uop_valid_o, uop_last_o, illegal_o, busy_o
  );
endinterface

// File: rtl/cv32e41p_zcmp_decoder.sv
// Combinational Zcmp decode: operation, register count, stack adjust and legality.
// CV32E41P_ZCMP_MV_EN additionally decodes cm.mvsa01 / cm.mva01s.
module cv32e41p_zcmp_decoder
  import cv32e41p_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STACK_ALIGN = 16,
  parameter int ADJ_W       = 12
) (
  input  logic [15:0]      instr,
  output zcmp_op_e         op,
  output logic [3:0]       n,
  output logic [ADJ_W-1:0] adj,
`ifdef CV32E41P_ZCMP_MV_EN
  output logic [4:0]       mv_r1,
  output logic [4:0]       mv_r2,
`endif
  output logic             legal
);

  localparam int SZ = XLEN / 8;

  logic [3:0] rlist;
  logic [1:0] spimm;
  logic       is_zcmp;

  assign rlist   = instr[7:4];
  assign spimm   = instr[3:2];
  assign is_zcmp = (instr[15:13] == 3'b101) && (instr[1:0] == 2'b10);
  assign n       = rlist_count(rlist);
  assign adj     = ADJ_W'(align_up(int'(n) * SZ, STACK_ALIGN) + int'(spimm) * 16);

`ifdef CV32E41P_ZCMP_MV_EN
  assign mv_r1 = sreg_regnum({1'b0, instr[9:7]});
  assign mv_r2 = sreg_regnum({1'b0, instr[4:2]});
`endif

  always_comb begin
    op    = PUSH;
    legal = 1'b0;
    if (is_zcmp) begin
      case (instr[12:8])
        5'b11000: begin op = PUSH;    legal = (rlist >= 4'd4); end
        5'b11010: begin op = POP;     legal = (rlist >= 4'd4); end
        5'b11100: begin op = POPRETZ; legal = (rlist >= 4'd4); end
        5'b11110: begin op = POPRET;  legal = (rlist >= 4'd4); end
        default: begin
`ifdef CV32E41P_ZCMP_MV_EN
          // moving a0/a1 into the same s-reg twice is reserved
          if (instr[12:10] == 3'b011 && instr[6:5] == 2'b01) begin
            op    = MVSA01;
            legal = (instr[9:7] != instr[4:2]);
          end else if (instr[12:10] == 3'b011 && instr[6:5] == 2'b11) begin
            op    = MVA01S;
            legal = 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/cv32e41p_zcmp_sequencer.sv
// Zcmp push/pop micro-op sequencer: expands one compressed instruction into base-ISA uops.
// CV32E41P_ZCMP_MV_EN adds the two-beat MV state for cm.mvsa01 / cm.mva01s.
module cv32e41p_zcmp_sequencer
  import cv32e41p_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STACK_ALIGN = 16,
  parameter int ADJ_W       = 12
) (
  input logic                      clk,
  input logic                      rst_n,
  cv32e41p_zcmp_sequencer_if.slave bus
);

  localparam int SZ = XLEN / 8;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("cv32e41p_zcmp_sequencer: XLEN must be 32 or 64");
  end
  if (STACK_ALIGN < XLEN / 8 || (STACK_ALIGN & (STACK_ALIGN - 1)) != 0) begin : g_bad_align
    $error("cv32e41p_zcmp_sequencer: STACK_ALIGN must be a power of two >= XLEN/8");
  end

  typedef enum logic [2:0] {
    IDLE, MEM, ADJ, ZERO, RET
`ifdef CV32E41P_ZCMP_MV_EN
    , MV
`endif
  } state_e;

  state_e           state_reg, state_next, start_state, gen_state;
  logic [3:0]       cnt_reg, cnt_next, gen_cnt, n_reg;
  zcmp_op_e         op_reg, gen_op, dec_op;
  logic [ADJ_W-1:0] adj_reg, gen_adj, dec_adj;
  logic [3:0]       dec_n;
  logic             dec_legal;
  logic [31:0]      uop_next;
  logic             last_next;
  logic [4:0]       reg_k;
`ifdef CV32E41P_ZCMP_MV_EN
  logic [4:0]       mv_r1_reg, mv_r2_reg, dec_r1, dec_r2, gen_r1, gen_r2;
`endif

  cv32e41p_zcmp_decoder #(
    .XLEN        (XLEN),
    .STACK_ALIGN (STACK_ALIGN),
    .ADJ_W       (ADJ_W)
  ) u_decoder (
    .instr (bus.instr_i),
    .op    (dec_op),
    .n     (dec_n),
    .adj   (dec_adj),
`ifdef CV32E41P_ZCMP_MV_EN
    .mv_r1 (dec_r1),
    .mv_r2 (dec_r2),
`endif
    .legal (dec_legal)
  );

`ifdef CV32E41P_ZCMP_MV_EN
  assign start_state = (dec_op == MVSA01 || dec_op == MVA01S) ? MV : MEM;
`else
  assign start_state = MEM;
`endif

  assign bus.instr_ready_o = (state_reg == IDLE);
  assign bus.busy_o        = (state_reg != IDLE);

  // Where the sequence goes after a non-final handshake
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MEM: begin
        if (cnt_reg == n_reg) state_next = ADJ;
        else                  cnt_next   = cnt_reg + 4'd1;
      end
      ADJ:  state_next = (op_reg == POPRETZ) ? ZERO : RET;
      ZERO: state_next = RET;
`ifdef CV32E41P_ZCMP_MV_EN
      MV:   cnt_next = cnt_reg + 4'd1;
`endif
      default: ;
    endcase
  end

  // The uop to register next: first beat comes straight from decode, later beats from held state
  always_comb begin
    if (state_reg == IDLE) begin
      gen_state = start_state;
      gen_cnt   = 4'd1;
      gen_op    = dec_op;
      gen_adj   = dec_adj;
`ifdef CV32E41P_ZCMP_MV_EN
      gen_r1    = dec_r1;
      gen_r2    = dec_r2;
`endif
    end else begin
      gen_state = state_next;
      gen_cnt   = cnt_next;
      gen_op    = op_reg;
      gen_adj   = adj_reg;
`ifdef CV32E41P_ZCMP_MV_EN
      gen_r1    = mv_r1_reg;
      gen_r2    = mv_r2_reg;
`endif
    end

    uop_next  = '0;
    last_next = 1'b0;
    reg_k     = (gen_cnt <= 4'd1) ? REG_RA : sreg_regnum(gen_cnt - 4'd2);
    case (gen_state)
      MEM: begin
        if (gen_op == PUSH)
          uop_next = enc_store(XLEN, reg_k, REG_SP, 12'(-(int'(gen_cnt) * SZ)));
        else
          uop_next = enc_load(XLEN, reg_k, REG_SP, 12'(int'(gen_adj) - int'(gen_cnt) * SZ));
      end
      ADJ: begin
        uop_next  = enc_addi(REG_SP, REG_SP,
                             (gen_op == PUSH) ? 12'(-int'(gen_adj)) : 12'(gen_adj));
        last_next = (gen_op == PUSH) || (gen_op == POP);
      end
      ZERO: uop_next = enc_addi(REG_A0, REG_ZERO, 12'd0);
      RET: begin
        uop_next  = UOP_RET;
        last_next = 1'b1;
      end
`ifdef CV32E41P_ZCMP_MV_EN
      MV: begin
        if (gen_op == MVSA01)
          uop_next = (gen_cnt == 4'd1) ? enc_addi(gen_r1, REG_A0, 12'd0)
                                       : enc_addi(gen_r2, REG_A1, 12'd0);
        else
          uop_next = (gen_cnt == 4'd1) ? enc_addi(REG_A0, gen_r1, 12'd0)
                                       : enc_addi(REG_A1, gen_r2, 12'd0);
        last_next = (gen_cnt == 4'd2);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      n_reg           <= 4'd0;
      op_reg          <= PUSH;
      adj_reg         <= '0;
`ifdef CV32E41P_ZCMP_MV_EN
      mv_r1_reg       <= 5'd0;
      mv_r2_reg       <= 5'd0;
`endif
      bus.uop_o       <= 32'd0;
      bus.uop_valid_o <= 1'b0;
      bus.uop_last_o  <= 1'b0;
      bus.illegal_o   <= 1'b0;
    end else begin
      bus.illegal_o <= 1'b0;
      if (bus.kill_i) begin
        state_reg       <= IDLE;
        cnt_reg         <= 4'd0;
        bus.uop_o       <= 32'd0;
        bus.uop_valid_o <= 1'b0;
        bus.uop_last_o  <= 1'b0;
      end else if (state_reg == IDLE) begin
        if (bus.instr_valid_i) begin
          if (!dec_legal) begin
            bus.illegal_o <= 1'b1;
          end else begin
            state_reg       <= start_state;
            cnt_reg         <= 4'd1;
            n_reg           <= dec_n;
            op_reg          <= dec_op;
            adj_reg         <= dec_adj;
`ifdef CV32E41P_ZCMP_MV_EN
            mv_r1_reg       <= dec_r1;
            mv_r2_reg       <= dec_r2;
`endif
            bus.uop_o       <= uop_next;
            bus.uop_valid_o <= 1'b1;
            bus.uop_last_o  <= last_next;
          end
        end
      end else if (bus.uop_ready_i) begin
        if (bus.uop_last_o) begin
          state_reg       <= IDLE;
          cnt_reg         <= 4'd0;
          bus.uop_o       <= 32'd0;
          bus.uop_valid_o <= 1'b0;
          bus.uop_last_o  <= 1'b0;
        end else begin
          state_reg      <= state_next;
          cnt_reg        <= cnt_next;
          bus.uop_o      <= uop_next;
          bus.uop_last_o <= last_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e41p_zcmp_sequencer.sv
// Directed self-checking bench for cv32e41p_zcmp_sequencer (XLEN=32 and XLEN=64 instances).
// Inputs change and outputs are sampled just after each falling edge.
module tb_cv32e41p_zcmp_sequencer;
  import cv32e41p_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  cv32e41p_zcmp_sequencer_if bus32 ();
  cv32e41p_zcmp_sequencer_if bus64 ();

  cv32e41p_zcmp_sequencer #(.XLEN(32), .STACK_ALIGN(16), .ADJ_W(12)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  cv32e41p_zcmp_sequencer #(.XLEN(64), .STACK_ALIGN(16), .ADJ_W(12)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle;
    bus32.instr_i = 16'h0; bus32.instr_valid_i = 1'b0; bus32.uop_ready_i = 1'b1; bus32.kill_i = 1'b0;
    bus64.instr_i = 16'h0; bus64.instr_valid_i = 1'b0; bus64.uop_ready_i = 1'b1; bus64.kill_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus32.instr_ready_o, bus32.uop_valid_o, bus32.uop_last_o, bus32.illegal_o, bus32.busy_o, bus32.uop_o} !== {5'b10000, 32'h0}) begin
      errors++;
      $display("FAIL reset32: got rdy/vld/last/ill/busy=%b uop=%h expected 10000 uop=00000000",
               {bus32.instr_ready_o, bus32.uop_valid_o, bus32.uop_last_o, bus32.illegal_o, bus32.busy_o}, bus32.uop_o);
    end else $display("reset32 ok");
    checks++;
    if ({bus64.instr_ready_o, bus64.uop_valid_o, bus64.uop_last_o, bus64.illegal_o, bus64.busy_o, bus64.uop_o} !== {5'b10000, 32'h0}) begin
      errors++;
      $display("FAIL reset64: got rdy/vld/last/ill/busy=%b uop=%h expected 10000 uop=00000000",
               {bus64.instr_ready_o, bus64.uop_valid_o, bus64.uop_last_o, bus64.illegal_o, bus64.busy_o}, bus64.uop_o);
    end else $display("reset64 ok");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // cm.push {ra,s0-s1}, spimm=1 on XLEN=32
  task automatic test_push;
    logic [31:0] exp [4];
    logic [33:0] got, want;
    exp = '{32'hFE112E23, 32'hFE812C23, 32'hFE912A23, 32'hFE010113};
    bus32.instr_i = 16'hB866; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
      want = {1'b1, (i == 3), exp[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL push_uop[%0d]: got vld/last/uop=%h expected %h", i, got, want);
      end else $display("push_uop[%0d] %h", i, bus32.uop_o);
      @(negedge clk);
    end
    checks++;
    if ({bus32.instr_ready_o, bus32.uop_valid_o, bus32.busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL push_end: got rdy/vld/busy=%b expected 100", {bus32.instr_ready_o, bus32.uop_valid_o, bus32.busy_o});
    end else $display("push_end idle");
  endtask

  // cm.popretz {ra,s0-s11}, spimm=3 on XLEN=32: the longest sequence
  task automatic test_popretz;
    logic [31:0] exp [16];
    logic [33:0] got, want;
    exp = '{32'h06C12083, 32'h06812403, 32'h06412483, 32'h06012903,
            32'h05C12983, 32'h05812A03, 32'h05412A83, 32'h05012B03,
            32'h04C12B83, 32'h04812C03, 32'h04412C83, 32'h04012D03,
            32'h03C12D83, 32'h07010113, 32'h00000513, 32'h00008067};
    bus32.instr_i = 16'hBCFE; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
      want = {1'b1, (i == 15), exp[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL popretz_uop[%0d]: got vld/last/uop=%h expected %h", i, got, want);
      end else $display("popretz_uop[%0d] %h", i, bus32.uop_o);
      @(negedge clk);
    end
    checks++;
    if ({bus32.uop_valid_o, bus32.busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL popretz_end: got vld/busy=%b expected 00", {bus32.uop_valid_o, bus32.busy_o});
    end else $display("popretz_end idle");
  endtask

  // cm.pop {ra,s0}, spimm=0 on XLEN=64
  task automatic test_pop64;
    logic [31:0] exp [3];
    logic [33:0] got, want;
    exp = '{32'h00813083, 32'h00013403, 32'h01010113};
    bus64.instr_i = 16'hBA52; bus64.instr_valid_i = 1'b1;
    @(negedge clk);
    bus64.instr_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got  = {bus64.uop_valid_o, bus64.uop_last_o, bus64.uop_o};
      want = {1'b1, (i == 2), exp[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pop64_uop[%0d]: got vld/last/uop=%h expected %h", i, got, want);
      end else $display("pop64_uop[%0d] %h", i, bus64.uop_o);
      @(negedge clk);
    end
    checks++;
    if ({bus64.uop_valid_o, bus64.busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL pop64_end: got vld/busy=%b expected 00", {bus64.uop_valid_o, bus64.busy_o});
    end else $display("pop64_end idle");
  endtask

  // Backpressure: stall the 2nd uop of a push for three cycles
  task automatic test_stall;
    logic [31:0] exp [4];
    logic [33:0] got, want;
    exp = '{32'hFE112E23, 32'hFE812C23, 32'hFE912A23, 32'hFE010113};
    bus32.instr_i = 16'hB866; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      int idx;
      idx = (c == 0) ? 0 : (c <= 4) ? 1 : c - 3;
      bus32.uop_ready_i = !(c >= 1 && c <= 3);
      got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
      want = {1'b1, (idx == 3), exp[idx]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall_cycle[%0d]: got vld/last/uop=%h expected %h", c, got, want);
      end else $display("stall_cycle[%0d] %h ready=%b", c, bus32.uop_o, bus32.uop_ready_i);
      @(negedge clk);
    end
    bus32.uop_ready_i = 1'b1;
    checks++;
    if ({bus32.uop_valid_o, bus32.busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL stall_end: got vld/busy=%b expected 00", {bus32.uop_valid_o, bus32.busy_o});
    end else $display("stall_end idle");
  endtask

  // Kill after the 2nd handshake of a push, then a new push is accepted at once
  task automatic test_kill;
    logic [33:0] got, want;
    bus32.instr_i = 16'hB866; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    bus32.kill_i = 1'b1;
    @(negedge clk);
    bus32.kill_i = 1'b0;
    checks++;
    if ({bus32.uop_valid_o, bus32.busy_o, bus32.instr_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL kill_flush: got vld/busy/rdy=%b expected 001", {bus32.uop_valid_o, bus32.busy_o, bus32.instr_ready_o});
    end else $display("kill_flush idle");
    bus32.instr_i = 16'hB842; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
    want = {2'b10, 32'hFE112E23};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL kill_restart0: got vld/last/uop=%h expected %h", got, want);
    end else $display("kill_restart0 %h", bus32.uop_o);
    @(negedge clk);
    got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
    want = {2'b11, 32'hFF010113};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL kill_restart1: got vld/last/uop=%h expected %h", got, want);
    end else $display("kill_restart1 %h", bus32.uop_o);
    @(negedge clk);
  endtask

  // Kill in IDLE drops a same-cycle instruction
  task automatic test_kill_idle;
    bus32.instr_i = 16'hB842; bus32.instr_valid_i = 1'b1; bus32.kill_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0; bus32.kill_i = 1'b0;
    checks++;
    if ({bus32.uop_valid_o, bus32.busy_o, bus32.illegal_o} !== 3'b000) begin
      errors++;
      $display("FAIL kill_idle: got vld/busy/ill=%b expected 000", {bus32.uop_valid_o, bus32.busy_o, bus32.illegal_o});
    end else $display("kill_idle dropped");
    @(negedge clk);
  endtask

  // Reserved encoding: one-cycle illegal pulse, no uops, stays idle
  task automatic test_illegal(input logic [15:0] enc, input string name);
    bus32.instr_i = enc; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    checks++;
    if ({bus32.illegal_o, bus32.uop_valid_o, bus32.busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL %s_pulse: got ill/vld/busy=%b expected 100", name, {bus32.illegal_o, bus32.uop_valid_o, bus32.busy_o});
    end else $display("%s_pulse ok", name);
    @(negedge clk);
    checks++;
    if ({bus32.illegal_o, bus32.uop_valid_o, bus32.busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL %s_after: got ill/vld/busy=%b expected 000", name, {bus32.illegal_o, bus32.uop_valid_o, bus32.busy_o});
    end else $display("%s_after ok", name);
  endtask

  // A held instr_valid_i is ignored while busy and taken right after the last uop
  task automatic test_back_to_back;
    logic [31:0] exp [5];
    logic [33:0] got, want;
    logic        lst [5];
    exp = '{32'hFE112E23, 32'hFF010113, 32'h00C12083, 32'h00812403, 32'h01010113};
    lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus32.instr_i = 16'hB842; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_i = 16'hBA52;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        checks++;
        if ({bus32.uop_valid_o, bus32.instr_ready_o} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_gap: got vld/rdy=%b expected 01", {bus32.uop_valid_o, bus32.instr_ready_o});
        end else $display("b2b_gap idle");
      end else begin
        int idx;
        idx = (i < 2) ? i : i - 1;
        got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
        want = {1'b1, lst[idx], exp[idx]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_uop[%0d]: got vld/last/uop=%h expected %h", idx, got, want);
        end else $display("b2b_uop[%0d] %h", idx, bus32.uop_o);
      end
      @(negedge clk);
      if (i == 2) bus32.instr_valid_i = 1'b0;
    end
  endtask

`ifdef CV32E41P_ZCMP_MV_EN
  // cm.mva01s s1,s2
  task automatic test_mv;
    logic [31:0] exp [2];
    logic [33:0] got, want;
    exp = '{32'h00048513, 32'h00090593};
    bus32.instr_i = 16'hACEA; bus32.instr_valid_i = 1'b1;
    @(negedge clk);
    bus32.instr_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got  = {bus32.uop_valid_o, bus32.uop_last_o, bus32.uop_o};
      want = {1'b1, (i == 1), exp[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mva01s_uop[%0d]: got vld/last/uop=%h expected %h", i, got, want);
      end else $display("mva01s_uop[%0d] %h", i, bus32.uop_o);
      @(negedge clk);
    end
    checks++;
    if ({bus32.uop_valid_o, bus32.busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL mva01s_end: got vld/busy=%b expected 00", {bus32.uop_valid_o, bus32.busy_o});
    end else $display("mva01s_end idle");
    test_illegal(16'hAC22, "mvsa01_same");
  endtask
`endif

  initial begin
    test_reset();
    test_push();
    test_popretz();
    test_pop64();
    test_stall();
    test_kill();
    test_kill_idle();
    test_illegal(16'hB832, "rlist3");
    test_back_to_back();
`ifdef CV32E41P_ZCMP_MV_EN
    test_mv();
`else
    test_illegal(16'hACEA, "mva01s_disabled");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
